// File: rtl/dispatch_pkg.sv
// Shared sizing, payload type and helpers for the renamer -> issue-queue dispatch stage.
// Widths live here so the FIFO entry struct and the port lists stay in lock-step.
package dispatch_pkg;

    localparam int INST_ID_BITS = 6;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int FU_COUNT     = 4;
    localparam int FU_SEL_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int NUM_PRN      = 2 ** PRN_BITS;

    localparam logic [PRN_BITS-1:0] PRN_ZERO = '0;

    typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_vec_t;

    typedef struct packed {
        logic [INST_ID_BITS-1:0] inst_id;
        logic [31:0]             raw_instr;
        logic [63:0]             pc;
        logic [FU_SEL_BITS-1:0]  fu_sel;
        logic [MAX_OPERANDS-1:0] prn_input_valid;
        prn_vec_t                prn_input;
        logic [MAX_OPERANDS-1:0] prn_output_valid;
        prn_vec_t                prn_output;
    } dispatch_entry_t;

    // Compare-based decode so an out-of-range selector yields an all-zero strobe.
    function automatic logic [FU_COUNT-1:0] fu_onehot(input logic [FU_SEL_BITS-1:0] sel);
        logic [FU_COUNT-1:0] v;
        v = '0;
        for (int s = 0; s < FU_COUNT; s++) begin
            if (sel == FU_SEL_BITS'(s)) begin
                v[s] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dispatch_unit_prn_scoreboard.sv
// Physical-register ready scoreboard: writeback broadcasts set bits, dispatched dests clear them.
// Lookups see the current bit OR any same-cycle broadcast so a freshly inserted slot is never missed.
module prn_scoreboard
    import dispatch_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    input  logic [NUM_PRN-1:0]                               clr_vec,
    input  logic [MAX_OPERANDS-1:0]                          lookup_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            lookup_prn,
    output logic [MAX_OPERANDS-1:0]                          lookup_ready
);

    logic [NUM_PRN-1:0] r_sb;
    logic [NUM_PRN-1:0] w_set_vec;
    logic [NUM_PRN-1:0] w_sb_next;

    always_comb begin
        w_set_vec = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (set_prn_ready[k][j]) begin
                    w_set_vec[set_prn[k][j]] = 1'b1;
                end
            end
        end
    end

    // Clear wins over set for the same PRN; PRN 0 is pinned ready.
    always_comb begin
        w_sb_next           = (r_sb | w_set_vec) & ~clr_vec;
        w_sb_next[PRN_ZERO] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '1;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    always_comb begin
        lookup_ready = '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            lookup_ready[j] = lookup_valid[j] &
                              (r_sb[lookup_prn[j]] | w_set_vec[lookup_prn[j]]);
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: small in-order FIFO of renamed instructions steered to one issue queue per FU,
// plus the PRN ready scoreboard that supplies source-ready bits at insert time.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [INST_ID_BITS-1:0]                             in_inst_id,
    input  logic [31:0]                                         in_raw_instr,
    input  logic [63:0]                                         in_pc,
    input  logic [FU_SEL_BITS-1:0]                              in_fu_sel,
    input  logic [MAX_OPERANDS-1:0]                             in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                             in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    input  logic [FU_COUNT-1:0]                                 iq_queue_ready,
    output logic [FU_COUNT-1:0]                                 iq_inst_valid,
    output logic [INST_ID_BITS-1:0]                             iq_inst_id,
    output logic [31:0]                                         iq_raw_instr,
    output logic [63:0]                                         iq_pc,
    output logic [MAX_OPERANDS-1:0]                             iq_prn_input_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               iq_prn_input,
    output logic [MAX_OPERANDS-1:0]                             iq_prn_input_ready,
    output logic [MAX_OPERANDS-1:0]                             iq_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               iq_prn_output
);

    localparam int PTR_BITS = $clog2(BUF_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    dispatch_entry_t       r_mem [BUF_DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;

    dispatch_entry_t       w_in_entry;
    dispatch_entry_t       w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_dispatch;
    logic                  w_sel_legal;
    logic [FU_COUNT-1:0]   w_strobe;
    logic [NUM_PRN-1:0]    w_clr_vec;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_BITS'(BUF_DEPTH));
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !flush;

    always_comb begin
        w_in_entry                  = '0;
        w_in_entry.inst_id          = in_inst_id;
        w_in_entry.raw_instr        = in_raw_instr;
        w_in_entry.pc               = in_pc;
        w_in_entry.fu_sel           = in_fu_sel;
        w_in_entry.prn_input_valid  = in_prn_input_valid;
        w_in_entry.prn_input        = in_prn_input;
        w_in_entry.prn_output_valid = in_prn_output_valid;
        w_in_entry.prn_output       = in_prn_output;
    end

    // Payload is zeroed when empty so downstream never sees stale FIFO contents.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    if ((1 << FU_SEL_BITS) > FU_COUNT) begin : g_sel_check
        assign w_sel_legal = (int'(w_head.fu_sel) < FU_COUNT);

        always_ff @(posedge clk) begin
            if (!rst && !flush && !w_empty && !w_sel_legal) begin
                $error("dispatch_unit: head fu_sel %0d out of range, dropped", w_head.fu_sel);
            end
        end
    end else begin : g_sel_full
        assign w_sel_legal = 1'b1;
    end

    assign w_strobe   = (w_empty || flush || !w_sel_legal) ? '0 : fu_onehot(w_head.fu_sel);
    assign w_dispatch = |(w_strobe & iq_queue_ready);
    // An illegal selector still pops so a bad entry cannot wedge the pipe.
    assign w_pop      = w_dispatch || (!w_empty && !flush && !w_sel_legal);

    always_comb begin
        w_clr_vec = '0;
        if (w_dispatch) begin
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (w_head.prn_output_valid[j] && (w_head.prn_output[j] != PRN_ZERO)) begin
                    w_clr_vec[w_head.prn_output[j]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    prn_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_prn_ready(set_prn_ready),
        .set_prn      (set_prn),
        .clr_vec      (w_clr_vec),
        .lookup_valid (w_head.prn_input_valid),
        .lookup_prn   (w_head.prn_input),
        .lookup_ready (iq_prn_input_ready)
    );

    assign iq_inst_valid       = w_strobe;
    assign iq_inst_id          = w_head.inst_id;
    assign iq_raw_instr        = w_head.raw_instr;
    assign iq_pc               = w_head.pc;
    assign iq_prn_input_valid  = w_head.prn_input_valid;
    assign iq_prn_input        = w_head.prn_input;
    assign iq_prn_output_valid = w_head.prn_output_valid;
    assign iq_prn_output       = w_head.prn_output;

endmodule
